// File: rtl/mem_access_seq.sv
// ---------------------------------------------------------------------------
// mem_access_seq
//
// Sequencing stage between the load/store unit and the Avalon memory adapter.
// It takes one request at a time and holds the word address, write data and
// write strobe stable toward the adapter until the fabric drops wait-request.
// It then captures read data and raises a one-cycle completion pulse. A
// wait-cycle counter aborts an access that the fabric never services.
//
// Ports
//   i_clk            sole clock, rising edge
//   i_rst            synchronous active-high reset
//   i_req            processor request (level, sampled only in IDLE)
//   i_req_addr[15:0] request word address
//   i_req_data[15:0] request write data
//   i_req_w          1 = write, 0 = read
//   o_busy           high while the access is in flight
//   o_done           one-cycle completion pulse
//   o_err            qualifies o_done: access timed out
//   o_rd_data[15:0]  last successfully read word
//   o_addr[15:0]     registered word address to the adapter
//   o_dout[15:0]     registered write data to the adapter
//   o_w              registered write strobe to the adapter
//   i_din[15:0]      read data from the adapter
//   i_wait_request   Avalon wait-request from the fabric
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for i_req; captures address/data/strobe on accept
//   S_ACCESS | transfer presented to the fabric, counting wait cycles
//   S_DONE   | completion pulse (o_done), o_err set if aborted
// ---------------------------------------------------------------------------
module mem_access_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [15:0] i_req_addr,
  input  logic [15:0] i_req_data,
  input  logic        i_req_w,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_rd_data,
  output logic [15:0] o_addr,
  output logic [15:0] o_dout,
  output logic        o_w,
  input  logic [15:0] i_din,
  input  logic        i_wait_request
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [15:0]   r_addr;
  logic [15:0]   r_dout;
  logic          r_w;
  logic [15:0]   r_rd_data;
  logic          w_last_wait;

  // Abort point: this wait cycle is the TIMEOUT_CYCLES-th consecutive one.
  assign w_last_wait = (r_cnt == C_LAST);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!i_wait_request || w_last_wait) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Output logic. Err is only visible during the completion pulse so it can
  // never leak into idle or in-flight cycles.
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    o_err  = 1'b0;
    case (r_state)
      S_ACCESS: o_busy = 1'b1;
      S_DONE: begin
        o_done = 1'b1;
        o_err  = r_err;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  // Datapath registers toward the adapter and back to the processor.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_addr    <= 16'h0000;
      r_dout    <= 16'h0000;
      r_w       <= 1'b0;
      r_rd_data <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_addr <= i_req_addr;
            r_dout <= i_req_data;
            r_w    <= i_req_w;
            r_cnt  <= '0;
            r_err  <= 1'b0;
          end else begin
            r_w <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (!i_wait_request) begin
            if (!r_w) begin
              r_rd_data <= i_din;
            end
            r_err <= 1'b0;
            r_w   <= 1'b0;
          end else if (w_last_wait) begin
            // Saturates here: the state leaves ACCESS, so r_cnt never wraps.
            r_err <= 1'b1;
            r_w   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_w <= 1'b0;
        end
        default: begin
          r_w <= 1'b0;
        end
      endcase
    end
  end

  assign o_addr    = r_addr;
  assign o_dout    = r_dout;
  assign o_w       = r_w;
  assign o_rd_data = r_rd_data;

endmodule
